jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Round-robin arbiter and sequencer for a shared bank of JK storage bits. Up to NREQ requesters each present a per-bit J/K command vector. The block grants one requester at a time, latches its command, and applies standard JK semantics to the shared state vector `q` one cycle later. It sits between the control agents and the flip-flop bank and guarantees that commands are never applied concurrently.

## Interface
Parameters:
- NREQ, 4: number of requesters, ≥2.
- WIDTH, 8: number of JK bits in the shared bank.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; reset is asserted when rst=0.
- req  in  NREQ  request vector; bit i asserts that requester i has a command pending.
- cmd_j  in  NREQ*WIDTH  J vectors; requester i uses slice [i*WIDTH +: WIDTH].
- cmd_k  in  NREQ*WIDTH  K vectors; slices are laid out the same way as cmd_j.
- clr  in  1  synchronous clear of the bank; highest priority.
- gnt  out  NREQ  one-hot grant, registered; high for exactly one cycle per grant.
- done  out  1  one-cycle pulse in the cycle after the command has been applied to q.
- busy  out  1  high while state=APPLY.
- q  out  WIDTH  shared JK bank state.

## Operation
- FSM states: IDLE and APPLY. The reset state is IDLE.
- IDLE with clr=0 and req≠0:
  - Select the winner w by round-robin search starting at ptr: ptr, ptr+1, …, with wrap modulo NREQ.
  - Latch cmd_j/cmd_k slice w into jq/kq.
  - Set gnt <= onehot(w) and ptr <= (w+1) mod NREQ.
  - Go to APPLY.
- IDLE with req=0: remain in IDLE; outputs stay 0 except q.
- APPLY with clr=0:
  - Update each bit b of q: J=0,K=0 holds; J=0,K=1 clears to 0; J=1,K=0 sets to 1; J=1,K=1 toggles to ~q[b].
  - Set gnt <= 0 and done <= 1. Return to IDLE.
- clr=1 in any state:
  - Next edge: q <= 0 and state <= IDLE.
  - Any latched command is discarded and done stays 0.
  - If clr=1 while in IDLE, no grant is issued that cycle and ptr is unchanged.
  - A gnt already high is still cleared on that edge.
- Requesters sample gnt. A requester must deassert req during its gnt cycle unless it has a further command. req is sampled only in IDLE, so a request held high is re-arbitrated as a new command.
- Command inputs must be stable only in the cycle when the block is in IDLE and req is asserted. They are don't-care at all other times.
- Width rules: ptr is ceil(log2(NREQ)) bits. When NREQ is not a power of two, wrap must be explicit: NREQ-1 wraps to 0.

## Timing
- Reset values: q=0, gnt=0, done=0, busy=0, ptr=0, state=IDLE, jq=kq=0.
- Reset assertion is asynchronous and takes effect immediately, including mid-APPLY; the pending command is lost.
- Reset is released synchronously to clk by the integrator. The first arbitration can happen on the first edge after release.
- Latency:
  - req sampled at edge E0.
  - gnt and busy are high in cycle E0..E1.
  - q is updated at E1; done is high in cycle E1..E2.
- Throughput: one command per 2 cycles.
- gnt and done are never high in the same cycle.
- Simultaneous requests: exactly one grant per arbitration. Under continuous load, requester i waits at most NREQ-1 other grants.

## Structure
- Shared package jk_pkg holds:
  - Localparams CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_TGL=2'b11, encoding the {J,K} bit pair.
  - The FSM state enum {IDLE, APPLY}.
- Natural sub-module: jk_bank, a WIDTH-wide registered JK vector.
  - Inputs: clk, rst, en, clr, j, k.
  - Output: q.
  - Implements the per-bit JK update when en=1.
  - The arbiter instantiates it once with en = (state==APPLY).
- The round-robin winner search is a combinational function inside jk_bank_arbiter.

## Test plan
- Reset: drive rst=0 mid-APPLY with q=8'hA5 → q=0, gnt=0 and busy=0 immediately; after release, no done pulse appears.
- Single request:
  - req=4'b0100, cmd_j slice2=8'hF0, cmd_k slice2=8'h0F, starting from q=8'h3C → gnt=4'b0100 for one cycle, then q=8'hF0 and done=1 one cycle later.
  - Next, J=K=8'hFF → q=8'h0F (toggle).
- Contention: req=4'b1111 held, with each requester's command recording its index → grant order 0,1,2,3,0; one gnt every 2 cycles; done interleaved.
- Fairness after a grant: with ptr=2, req=4'b0011 → grant 0 first, then 1; ptr ends at 2.
- Clear priority:
  - clr=1 in the APPLY cycle with J=8'hFF, K=0 → q=0 and no done.
  - clr=1 in IDLE with req=4'b0001 → no gnt that cycle; grant goes out on the following cycle.
- NREQ=3 build: req=3'b111 → order 0,1,2,0 with correct wrap; gnt is never 3'b000 while busy.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: {J,K} command encodings,
// FSM state type and the single-bit JK next-state function.
package jk_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic {IDLE, APPLY} arbState_e;

  function automatic logic jkNext(input logic q, input logic j, input logic k);
    logic n;
    case ({j, k})
      CMD_HOLD: n = q;
      CMD_CLR:  n = 1'b0;
      CMD_SET:  n = 1'b1;
      CMD_TGL:  n = ~q;
      default:  n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// WIDTH-wide registered JK vector; clr wins over en and empties the bank.
module jk_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_d;

  always_comb begin
    bank_d = bank_q;
    for (int b = 0; b < WIDTH; b++) begin
      bank_d[b] = jkNext(bank_q[b], j[b], k[b]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else if (clr) begin
      bank_q <= '0;
    end else if (en) begin
      bank_q <= bank_d;
    end
  end

  assign q = bank_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that latches one requester's J/K command per
// arbitration and applies it to the shared JK bank in the following cycle.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] cmd_j,
  input  logic [NREQ*WIDTH-1:0] cmd_k,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arbState_e        state_q;
  logic [PW-1:0]    ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic             done_q;
  logic [WIDTH-1:0] jCmd_q;
  logic [WIDTH-1:0] kCmd_q;

  logic [PW-1:0]    win_d;
  logic [PW-1:0]    ptr_d;
  logic [WIDTH-1:0] jSel_d;
  logic [WIDTH-1:0] kSel_d;

  // Search ptr, ptr+1, ... with explicit wrap so non-power-of-two NREQ works.
  function automatic logic [PW-1:0] rrPick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          hit;
    int            idx;
    w   = p;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(p) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && r[idx[PW-1:0]]) begin
        w   = idx[PW-1:0];
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    win_d  = rrPick(req, ptr_q);
    ptr_d  = (win_d == PW'(NREQ - 1)) ? '0 : win_d + 1'b1;
    jSel_d = '0;
    kSel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_d == PW'(i)) begin
        jSel_d = cmd_j[i*WIDTH +: WIDTH];
        kSel_d = cmd_k[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      jCmd_q  <= '0;
      kCmd_q  <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      jCmd_q  <= '0;
      kCmd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (|req) begin
            jCmd_q  <= jSel_d;
            kCmd_q  <= kSel_d;
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
            ptr_q   <= ptr_d;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          gnt_q   <= '0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  jk_bank #(.WIDTH(WIDTH)) uBank (
    .clk (clk),
    .rst (rst),
    .en  (state_q == APPLY),
    .clr (clr),
    .j   (jCmd_q),
    .k   (kCmd_q),
    .q   (q)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q == APPLY);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/results, a negedge
// monitor pops and compares whenever the arbiter presents gnt or done.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req;
  logic [31:0] cmdJ, cmdK;
  logic        clr;
  logic [3:0]  gnt;
  logic        done, busy;
  logic [7:0]  q;

  logic [2:0]  req3, gnt3;
  logic [23:0] cmdJ3, cmdK3;
  logic        clr3, done3, busy3;
  logic [7:0]  q3;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  int lastGntCycle = -1;
  logic spacingMode = 1'b0;

  logic [3:0] expGnt[$];
  logic [7:0] expQ[$];
  logic [2:0] expGnt3[$];

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_j(cmdJ), .cmd_k(cmdK), .clr(clr),
    .gnt(gnt), .done(done), .busy(busy), .q(q)
  );

  jk_bank_arbiter #(.NREQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .cmd_j(cmdJ3), .cmd_k(cmdK3), .clr(clr3),
    .gnt(gnt3), .done(done3), .busy(busy3), .q(q3)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
  endtask

  task automatic noteUnexpected(input string name, input logic [31:0] actual);
    checkCount++;
    $display("[TB] FAIL %s: got 'h%0h, expected nothing pending", name, actual);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic c);
    req = r;
    clr = c;
  endtask

  task automatic setCmd(input int i, input logic [7:0] j, input logic [7:0] k);
    cmdJ[i*8 +: 8] = j;
    cmdK[i*8 +: 8] = k;
  endtask

  task automatic issueCmd(input logic [3:0] r, input logic [3:0] eg, input logic [7:0] eq);
    expGnt.push_back(eg);
    expQ.push_back(eq);
    applyStimulus(r, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 1'b0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    cycleCount++;
    if (rst) begin
      if ((|gnt) || done || busy) begin
        checkOutput("gntDoneExclusive", 32'((|gnt) & done), 32'd0);
        checkOutput("busyTracksGnt", 32'(busy), 32'(|gnt));
      end
      if (|gnt) begin
        if (spacingMode && lastGntCycle >= 0)
          checkOutput("gntSpacing", cycleCount - lastGntCycle, 32'd2);
        lastGntCycle = cycleCount;
        if (expGnt.size() == 0) noteUnexpected("gntUnexpected", 32'(gnt));
        else checkOutput("gntOrder", 32'(gnt), 32'(expGnt.pop_front()));
      end
      if (done) begin
        if (expQ.size() == 0) noteUnexpected("doneUnexpected", 32'(q));
        else checkOutput("qAfterDone", 32'(q), 32'(expQ.pop_front()));
      end
      if (busy3) checkOutput("gnt3NonZeroWhileBusy", 32'(|gnt3), 32'd1);
      if (|gnt3) begin
        if (expGnt3.size() == 0) noteUnexpected("gnt3Unexpected", 32'(gnt3));
        else checkOutput("gnt3Order", 32'(gnt3), 32'(expGnt3.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req = '0; clr = 1'b0; cmdJ = '0; cmdK = '0;
    req3 = '0; clr3 = 1'b0; cmdJ3 = '0; cmdK3 = '0;
    #2;
    checkOutput("resetQ", 32'(q), 32'd0);
    checkOutput("resetGnt", 32'(gnt), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Contention: each requester's command writes its own index into q.
    for (int i = 0; i < 4; i++) setCmd(i, 8'(i), ~8'(i));
    expGnt.push_back(4'b0001); expQ.push_back(8'h00);
    expGnt.push_back(4'b0010); expQ.push_back(8'h01);
    expGnt.push_back(4'b0100); expQ.push_back(8'h02);
    expGnt.push_back(4'b1000); expQ.push_back(8'h03);
    expGnt.push_back(4'b0001); expQ.push_back(8'h00);
    spacingMode = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    repeat (9) @(posedge clk);
    #1 applyStimulus(4'b0000, 1'b0);
    @(posedge clk); #1;
    spacingMode = 1'b0;

    setCmd(1, 8'h3C, 8'hC3); issueCmd(4'b0010, 4'b0010, 8'h3C);
    setCmd(2, 8'hF0, 8'h0F); issueCmd(4'b0100, 4'b0100, 8'hF0);
    setCmd(2, 8'hFF, 8'hFF); issueCmd(4'b0100, 4'b0100, 8'h0F);
    setCmd(1, 8'h00, 8'h00); issueCmd(4'b0010, 4'b0010, 8'h0F);

    // ptr is now 2: requesters 0 and 1 must be served 0 first, then 1.
    setCmd(0, 8'h80, 8'h00);
    setCmd(1, 8'h00, 8'h0F);
    expGnt.push_back(4'b0001); expQ.push_back(8'h8F);
    expGnt.push_back(4'b0010); expQ.push_back(8'h80);
    applyStimulus(4'b0011, 1'b0);
    repeat (3) @(posedge clk);
    #1 applyStimulus(4'b0000, 1'b0);
    @(posedge clk); #1;
    setCmd(2, 8'h01, 8'h00); issueCmd(4'b1111, 4'b0100, 8'h81);

    // Clear during APPLY discards the pending set-all command.
    setCmd(3, 8'hFF, 8'h00);
    expGnt.push_back(4'b1000);
    applyStimulus(4'b1000, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 1'b1);
    @(posedge clk); #1;
    checkOutput("clrApplyQ", 32'(q), 32'd0);
    checkOutput("clrApplyDone", 32'(done), 32'd0);
    checkOutput("clrApplyBusy", 32'(busy), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    @(posedge clk); #1;
    checkOutput("clrApplyNoLateDone", 32'(done), 32'd0);

    // Clear in IDLE suppresses the grant for that edge only.
    applyStimulus(4'b0001, 1'b1);
    @(posedge clk); #1;
    checkOutput("clrIdleNoGnt", 32'(gnt), 32'd0);
    checkOutput("clrIdleNotBusy", 32'(busy), 32'd0);
    expGnt.push_back(4'b0001); expQ.push_back(8'h80);
    applyStimulus(4'b0001, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an APPLY with q=A5.
    setCmd(1, 8'hA5, 8'h5A); issueCmd(4'b0010, 4'b0010, 8'hA5);
    setCmd(2, 8'hFF, 8'hFF);
    expGnt.push_back(4'b0100);
    applyStimulus(4'b0100, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 1'b0);
    #5 rst = 1'b0;
    #1;
    checkOutput("rstMidApplyQ", 32'(q), 32'd0);
    checkOutput("rstMidApplyGnt", 32'(gnt), 32'd0);
    checkOutput("rstMidApplyBusy", 32'(busy), 32'd0);
    checkOutput("rstMidApplyDone", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rstNoDone", 32'(done), 32'd0);
    end
    issueCmd(4'b1111, 4'b0001, 8'h80);

    // Three-requester build: wrap from 2 back to 0.
    expGnt3.push_back(3'b001);
    expGnt3.push_back(3'b010);
    expGnt3.push_back(3'b100);
    expGnt3.push_back(3'b001);
    req3 = 3'b111;
    repeat (7) @(posedge clk);
    #1 req3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("expGntDrained", expGnt.size(), 32'd0);
    checkOutput("expQDrained", expQ.size(), 32'd0);
    checkOutput("expGnt3Drained", expGnt3.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
